// File: rtl/template_store.sv
// Captures a TW x TH window of the camera stream into a simple dual-port RAM
// and replays it on the VGA side at a fixed display position.
module template_store #(
  parameter int unsigned TW      = 40,
  parameter int unsigned TH      = 40,
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DISP_X0 = 0,
  parameter int unsigned DISP_Y0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              cam_vsync,
  input  logic              cam_valid,
  input  logic [9:0]        capture_x,
  input  logic [9:0]        capture_y,
  input  logic [PIX_W-1:0]  cam_pixel,
  input  logic [9:0]        win_x,
  input  logic [9:0]        win_y,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [PIX_W-1:0]  template_pixel,
  output logic              template_valid,
  output logic              capturing,
  output logic              ready,
  output logic [ADDR_W:0]   pix_count
);

  localparam int unsigned    NPIX     = TW * TH;
  localparam int unsigned    MEM_D    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NPIX - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_capturing;
  logic               r_ready;
  logic [9:0]         r_lx;
  logic [9:0]         r_ly;
  logic [ADDR_W:0]    r_pix_count;
  logic [PIX_W-1:0]   r_mem [MEM_D];
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_rin;
  logic [PIX_W-1:0]   r_tpix;
  logic               r_tvalid;

  logic [9:0]         w_dx;
  logic [9:0]         w_dy;
  logic               w_in_win;
  logic               w_wr;
  logic [ADDR_W-1:0]  w_waddr;
  logic [9:0]         w_rx;
  logic [9:0]         w_ry;

  // Write-side window offsets; negative offsets wrap large and fall outside.
  assign w_dx     = capture_x - r_lx;
  assign w_dy     = capture_y - r_ly;
  assign w_in_win = (32'(w_dx) < TW) && (32'(w_dy) < TH);
  assign w_wr     = (r_state == CAPTURE) && cam_valid && !cam_vsync && w_in_win;
  assign w_waddr  = ADDR_W'(32'(w_dy) * TW + 32'(w_dx));

  assign w_rx = x - 10'(DISP_X0);
  assign w_ry = y - 10'(DISP_Y0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (capture_start) w_state_nxt = ARMED;
      ARMED:   if (cam_vsync) w_state_nxt = CAPTURE;
      CAPTURE: begin
        if (cam_vsync) begin
          w_state_nxt = READY;
        end else if (w_wr && (r_pix_count == LAST_CNT)) begin
          w_state_nxt = READY;
        end
      end
      READY:   if (capture_start) w_state_nxt = ARMED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flags, window latch and write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_capturing <= 1'b0;
      r_ready     <= 1'b0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_pix_count <= '0;
    end else begin
      r_capturing <= (w_state_nxt == CAPTURE);
      r_ready     <= (w_state_nxt == READY);
      if ((r_state == ARMED) && cam_vsync) begin
        r_lx        <= win_x;
        r_ly        <= win_y;
        r_pix_count <= '0;
      end else if (w_wr) begin
        r_pix_count <= r_pix_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_waddr] <= cam_pixel;
    end
  end

  // Two-stage readout: address/in-window, then RAM data and gated valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr  <= '0;
      r_rin    <= 1'b0;
      r_tpix   <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_raddr  <= ADDR_W'(32'(w_ry) * TW + 32'(w_rx));
      r_rin    <= (32'(w_rx) < TW) && (32'(w_ry) < TH);
      r_tpix   <= r_mem[r_raddr];
      r_tvalid <= r_rin && (r_state == READY);
    end
  end

  assign template_pixel = r_tpix;
  assign template_valid = r_tvalid;
  assign capturing      = r_capturing;
  assign ready          = r_ready;
  assign pix_count      = r_pix_count;

endmodule

// File: tb/tb_template_store.sv
// Randomised bench for template_store against a behavioural capture/readout model.
module tb_template_store;

  localparam int unsigned TW = 40, TH = 40, PIX_W = 12, ADDR_W = 11;
  localparam int unsigned DX0 = 0, DY0 = 0;
  localparam int NPIX = TW * TH;

  logic              clk = 1'b0;
  logic              rst, capture_start, cam_vsync, cam_valid;
  logic [9:0]        capture_x, capture_y, win_x, win_y, x, y;
  logic [PIX_W-1:0]  cam_pixel;
  logic [PIX_W-1:0]  template_pixel;
  logic              template_valid, capturing, ready;
  logic [ADDR_W:0]   pix_count;

  template_store #(.TW(TW), .TH(TH), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
                   .DISP_X0(DX0), .DISP_Y0(DY0)) dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .cam_vsync(cam_vsync),
    .cam_valid(cam_valid), .capture_x(capture_x), .capture_y(capture_y),
    .cam_pixel(cam_pixel), .win_x(win_x), .win_y(win_y), .x(x), .y(y),
    .template_pixel(template_pixel), .template_valid(template_valid),
    .capturing(capturing), .ready(ready), .pix_count(pix_count));

  always #5 clk = ~clk;

  // Model: 0 idle, 1 armed, 2 capturing, 3 ready
  int               m_st, m_cnt, m_lx, m_ly;
  logic [PIX_W-1:0] ref_mem [2048];
  bit               known   [2048];
  bit               p_in;
  int               p_addr;
  bit               e_tv;
  logic [PIX_W-1:0] e_tp;
  int               n_cmp = 0, n_bad = 0;
  int               wx, wy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply current inputs for one clock, advance the model, then check outputs.
  task automatic step();
    int pre_st, dx, dy, rx, ry, a, ea;
    pre_st = m_st;
    ea = p_addr;
    if (rst) begin
      e_tv = 1'b0; e_tp = '0; p_in = 1'b0; p_addr = 0; ea = 0;
    end else begin
      e_tv = p_in && (pre_st == 3);
      e_tp = ref_mem[ea];
      rx = (int'(x) - int'(DX0)) & 1023;
      ry = (int'(y) - int'(DY0)) & 1023;
      p_in = (rx < int'(TW)) && (ry < int'(TH));
      p_addr = (ry * int'(TW) + rx) % 2048;
    end
    if (rst) begin
      m_st = 0; m_cnt = 0; m_lx = 0; m_ly = 0;
    end else begin
      case (m_st)
        0: if (capture_start) m_st = 1;
        1: if (cam_vsync) begin m_st = 2; m_lx = int'(win_x); m_ly = int'(win_y); m_cnt = 0; end
        2: begin
          if (cam_vsync) m_st = 3;
          else if (cam_valid) begin
            dx = (int'(capture_x) - m_lx) & 1023;
            dy = (int'(capture_y) - m_ly) & 1023;
            if (dx < int'(TW) && dy < int'(TH)) begin
              a = dy * int'(TW) + dx;
              ref_mem[a] = cam_pixel;
              known[a] = 1'b1;
              m_cnt++;
              if (m_cnt == NPIX) m_st = 3;
            end
          end
        end
        default: if (capture_start) m_st = 1;
      endcase
    end
    @(posedge clk); #1;
    chk("capturing", 32'(capturing), 32'(m_st == 2));
    chk("ready", 32'(ready), 32'(m_st == 3));
    chk("pix_count", 32'(pix_count), 32'(m_cnt));
    chk("template_valid", 32'(template_valid), 32'(e_tv));
    if (rst) chk("template_pixel_rst", 32'(template_pixel), 32'(0));
    else if (e_tv && known[ea]) chk("template_pixel", 32'(template_pixel), 32'(e_tp));
  endtask

  task automatic pulse_start_vsync();
    capture_start = 1'b1; step(); capture_start = 1'b0;
    step();
    cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
  endtask

  // Raster-scan a region with random idle gaps; stops when the model leaves capture.
  task automatic stream(input int x0, input int x1, input int y0, input int y1,
                        input bit rnd_pix, input bit wiggle, input int budget);
    int used = 0;
    for (int yy = y0; yy <= y1 && m_st == 2 && used < budget; yy++) begin
      for (int xx = x0; xx <= x1 && m_st == 2 && used < budget; xx++) begin
        do begin
          cam_valid = ($urandom_range(3) != 0);
          capture_x = 10'(xx);
          capture_y = 10'(yy);
          cam_pixel = rnd_pix ? 12'($urandom) : {capture_y[5:0], capture_x[5:0]};
          if (wiggle) begin
            win_x = 10'($urandom);
            win_y = 10'($urandom);
            capture_start = 1'($urandom_range(1));
          end
          step();
          capture_start = 1'b0;
          used++;
        end while (!cam_valid);
      end
    end
    cam_valid = 1'b0;
  endtask

  task automatic readout();
    for (int yy = 0; yy < int'(TH) + 2; yy++) begin
      for (int xx = 0; xx < int'(TW) + 2; xx++) begin
        x = 10'(xx); y = 10'(yy);
        step();
      end
    end
    x = 10'd700; y = 10'd500;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; capture_start = 1'b0; cam_vsync = 1'b0; cam_valid = 1'b0;
    capture_x = '0; capture_y = '0; cam_pixel = '0; win_x = '0; win_y = '0;
    x = '0; y = '0;
    m_st = 0; m_cnt = 0; m_lx = 0; m_ly = 0; p_in = 0; p_addr = 0;
    repeat (3) step();
    rst = 1'b0;

    // Idle readout stays invalid
    x = 10'd5; y = 10'd5;
    repeat (10) step();
    chk("idle_valid", 32'(template_valid), 32'(0));

    // Full-window capture at (300,220)
    win_x = 10'd300; win_y = 10'd220;
    pulse_start_vsync();
    stream(290, 349, 210, 269, 1'b0, 1'b0, 20000);
    chk("cap1_count", 32'(pix_count), 32'(1600));
    chk("cap1_ready", 32'(ready), 32'(1));
    x = 10'd3; y = 10'd2; step();
    x = 10'd700; step();
    chk("cap1_spot_valid", 32'(template_valid), 32'(1));
    chk("cap1_spot_pix", 32'(template_pixel), 32'({6'd30, 6'd47}));
    readout();

    // Window clipped at the frame corner: only 10x10 lands, vsync ends it
    win_x = 10'd630; win_y = 10'd470;
    pulse_start_vsync();
    stream(620, 639, 460, 479, 1'b1, 1'b0, 20000);
    chk("cap2_count", 32'(pix_count), 32'(100));
    chk("cap2_not_ready", 32'(ready), 32'(0));
    cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
    chk("cap2_ready", 32'(ready), 32'(1));
    readout();

    // Re-arm from READY, then start+vsync together in ARMED; window wiggles mid-capture
    wx = int'($urandom_range(5, 590)); wy = int'($urandom_range(5, 430));
    capture_start = 1'b1; step(); capture_start = 1'b0;
    win_x = 10'(wx); win_y = 10'(wy);
    capture_start = 1'b1; cam_vsync = 1'b1; step();
    capture_start = 1'b0; cam_vsync = 1'b0;
    chk("same_cycle_capturing", 32'(capturing), 32'(1));
    stream(wx - 5, wx + 44, wy - 5, wy + 44, 1'b1, 1'b1, 20000);
    chk("cap3_ready", 32'(ready), 32'(1));
    readout();

    // Reset mid-capture, then a clean capture
    wx = int'($urandom_range(0, 600)); wy = int'($urandom_range(0, 440));
    win_x = 10'(wx); win_y = 10'(wy);
    pulse_start_vsync();
    stream(wx, wx + 39, wy, wy + 39, 1'b1, 1'b0, 300);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_capturing", 32'(capturing), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_count", 32'(pix_count), 32'(0));
    step();
    wx = int'($urandom_range(0, 600)); wy = int'($urandom_range(0, 440));
    win_x = 10'(wx); win_y = 10'(wy);
    pulse_start_vsync();
    stream(wx, wx + 39, wy, wy + 39, 1'b1, 1'b0, 20000);
    chk("cap4_count", 32'(pix_count), 32'(1600));
    readout();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/template_store.md
Name: template_store

Overview:
- Captures a TW x TH pixel template from the camera stream into on-chip RAM.
- The capture window is given by its top-left corner in capture coordinates, which the box overlay logic supplies.
- Reads the stored template back on the VGA side so it can be overlaid at a fixed display position.
- Sits between the box/capture logic (writer side) and the VGA pixel mux (reader side). Single clock domain.

Parameters:
- TW, 40, template width in pixels
- TH, 40, template height in pixels
- PIX_W, 12, pixel width (RGB444)
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= TW*TH
- DISP_X0, 0, display x of template top-left on readout
- DISP_Y0, 0, display y of template top-left on readout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- capture_start  in  1  one-cycle pulse; arms a capture
- cam_vsync  in  1  one-cycle pulse at camera frame start
- cam_valid  in  1  capture_x/capture_y/cam_pixel valid this cycle
- capture_x  in  10  camera pixel x
- capture_y  in  10  camera pixel y
- cam_pixel  in  PIX_W  camera pixel data
- win_x  in  10  capture window left edge (box centre x - 20)
- win_y  in  10  capture window top edge (box centre y - 20)
- x  in  10  VGA display x
- y  in  10  VGA display y
- template_pixel  out  PIX_W  readout pixel
- template_valid  out  1  template_pixel is meaningful for this display position
- capturing  out  1  FSM in CAPTURE
- ready  out  1  FSM in READY
- pix_count  out  ADDR_W+1  pixels written in the current or last capture

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; capturing, ready, template_valid=0; template_pixel=0; pix_count=0; latched window=0. RAM contents are not cleared.
- FSM states: IDLE, ARMED, CAPTURE, READY.
  - IDLE -> ARMED on capture_start.
  - ARMED -> CAPTURE on cam_vsync. If capture_start and cam_vsync arrive in the same cycle, vsync wins.
  - CAPTURE -> READY on the next cam_vsync (one full frame captured).
  - CAPTURE -> READY also on the cycle whose write makes pix_count == TW*TH. That write still happens.
  - READY -> ARMED on capture_start; ready drops the next cycle.
  - capture_start in ARMED or CAPTURE is ignored.
- Window latch:
  - On the ARMED->CAPTURE transition, register win_x/win_y into lx/ly and clear pix_count to 0.
  - Window inputs changing during CAPTURE have no effect.
- Write path:
  - Active in CAPTURE with cam_valid=1.
  - dx = capture_x - lx, dy = capture_y - ly, both 10-bit unsigned with wrap.
  - Pixel is in-window iff dx < TW and dy < TH. Negative offsets wrap large and are excluded.
  - If in-window: mem[dy*TW + dx] <= cam_pixel and pix_count increments.
  - The cam_vsync cycle that ends CAPTURE performs no write.
  - Duplicate coordinates overwrite the same RAM entry and still count.
- Read path, 2-cycle latency:
  - Cycle 1 registers rx = x - DISP_X0, ry = y - DISP_Y0, rin = (rx<TW && ry<TH), and addr = ry*TW + rx.
  - Cycle 2 outputs template_pixel = mem[addr] and template_valid = rin && ready.
  - Outside the window, template_pixel is don't-care; benches check only when template_valid=1.
  - RAM is simple dual-port: one write port, one synchronous read port.
  - A read and a write to the same address in the same cycle returns the old data. Unreachable anyway, since valid requires READY.
- ready=1 only in READY. Readout is suppressed (template_valid=0) in all other states, including during a re-capture.
- Reset mid-CAPTURE: returns to IDLE the next cycle. pix_count=0. Partial RAM data is kept but unreadable until a capture completes.
- Multipliers are by the constant TW; a shift-add implementation is acceptable.

Test Plan:
- Reset, then x=5,y=5 driven for 10 cycles -> template_valid=0, ready=0, state IDLE.
- capture_start; cam_vsync; win=(300,220); stream a full 640x480 frame with cam_pixel={capture_y[5:0],capture_x[5:0]} -> pix_count=1600, ready=1 on the cycle after the 1600th write. Readout at x=3,y=2 two cycles later -> template_pixel={6'd222,6'd303 low bits}, template_valid=1.
- win=(630,470); full frame -> only 10x10 in-range pixels written. pix_count stays 100; READY entered on the next cam_vsync.
- Change win_x mid-CAPTURE -> written data still matches the latched window.
- Same-cycle capture_start and cam_vsync in ARMED -> CAPTURE entered, capturing=1.
- rst asserted mid-CAPTURE -> next cycle capturing=0, ready=0, pix_count=0. A later full capture proceeds normally.
